pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/stall_timer.sv | 42 ++++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StExBusy = 1'b1
  } state_e;

  // Hold vectors: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam logic [5:0]  STALL_NONE  = 6'b000000;
  localparam logic [5:0]  STALL_ID    = 6'b000111;
  localparam logic [5:0]  STALL_EX    = 6'b001111;

  localparam logic [7:0]  WDOG_LIMIT  = 8'd255;
  localparam logic [31:0] WDOG_VECTOR = 32'h0000_0020;

endpackage

// File: rtl/stall_timer.sv
// Remaining-cycle counter for multi-cycle EX operations: load, decrement, clear.
module stall_timer
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [5:0] load_val_i,
  input  logic       dec_i,
  input  logic       clr_i,
  output logic [5:0] value_o,
  output logic       zero_o,
  output logic       expire_o
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 6'd0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 6'd0)) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o  = cnt_q;
  assign zero_o   = (cnt_q == 6'd0);
  // A decrement this cycle lands on zero.
  assign expire_o = (cnt_q <= 6'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, flush/redirect and multi-cycle EX hold.
// Optional stall watchdog enabled by defining PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        ex_start,
  input  logic [5:0]  ex_cycles,
  input  logic        flush_req,
  input  logic [31:0] new_pc_in,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic        wd_err
);

  state_e     state_q, state_d;
  logic       tmr_load, tmr_dec, tmr_clr;
  logic [5:0] tmr_load_val, tmr_value;
  logic       tmr_zero, tmr_expire;
  logic       wd_fire;

`ifdef PIPE_CTRL_WATCHDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       wd_err_q, wd_err_d;
`endif

  stall_timer u_stall_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .clr_i      (tmr_clr),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'd0;
    tmr_load     = 1'b0;
    tmr_load_val = 6'd0;
    tmr_dec      = 1'b0;
    tmr_clr      = 1'b0;
    wd_fire      = 1'b0;

    if (flush_req) begin
      flush   = 1'b1;
      new_pc  = new_pc_in;
      state_d = StIdle;
      tmr_clr = 1'b1;
    end else if (state_q == StExBusy) begin
      stall   = STALL_EX;
      tmr_dec = 1'b1;
      if (tmr_expire) begin
        state_d = StIdle;
      end
    end else if (ex_start && (ex_cycles != 6'd0)) begin
      stall        = STALL_EX;
      tmr_load     = 1'b1;
      tmr_load_val = ex_cycles - 6'd1;
      // A one-cycle op is fully covered by this cycle's stall.
      state_d      = (ex_cycles == 6'd1) ? StIdle : StExBusy;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end

`ifdef PIPE_CTRL_WATCHDOG_EN
    // The 255th consecutive stalled cycle is replaced by a redirect.
    if ((stall != STALL_NONE) && (wdog_q == WDOG_LIMIT - 8'd1)) begin
      wd_fire  = 1'b1;
      stall    = STALL_NONE;
      flush    = 1'b1;
      new_pc   = WDOG_VECTOR;
      state_d  = StIdle;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_clr  = 1'b1;
    end
`endif
  end

`ifdef PIPE_CTRL_WATCHDOG_EN
  always_comb begin
    wdog_d   = (stall != STALL_NONE) ? (wdog_q + 8'd1) : 8'd0;
    wd_err_d = wd_err_q | wd_fire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q   <= 8'd0;
      wd_err_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == StExBusy);

  logic unused_ok;
  assign unused_ok = ^{tmr_value, tmr_zero, wd_fire};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; watchdog scenario follows PIPE_CTRL_WATCHDOG_EN.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, ex_start, flush_req;
  logic [5:0]  ex_cycles;
  logic [31:0] new_pc_in;
  logic [5:0]  stall;
  logic        flush, busy, wd_err;
  logic [31:0] new_pc;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .ex_start    (ex_start),
    .ex_cycles   (ex_cycles),
    .flush_req   (flush_req),
    .new_pc_in   (new_pc_in),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .busy        (busy),
    .wd_err      (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    ex_start    = 1'b0;
    ex_cycles   = 6'd0;
    flush_req   = 1'b0;
    new_pc_in   = 32'd0;
  endtask

  task automatic check_out(input string name, input logic [5:0] exp_stall,
                           input logic exp_flush, input logic [31:0] exp_pc,
                           input logic exp_busy);
    n_cmp++;
    if (stall !== exp_stall || flush !== exp_flush || new_pc !== exp_pc ||
        busy !== exp_busy) begin
      n_err++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h busy=%b, want stall=%b flush=%b new_pc=%h busy=%b",
               name, stall, flush, new_pc, busy, exp_stall, exp_flush, exp_pc, exp_busy);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    check_out("reset_held", 6'b000000, 1'b0, 32'd0, 1'b0);
    n_cmp++;
    if (wd_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wd_err: got %b want 0", wd_err);
    end
    tick();
    rst = 1'b1;
    tick();
    settle();
    check_out("reset_release", 6'b000000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_multicycle();
    tick();
    ex_start  = 1'b1;
    ex_cycles = 6'd5;
    settle();
    check_out("mc5_start", 6'b001111, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      idle_inputs();
      settle();
      check_out($sformatf("mc5_busy%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1);
    end
    tick();
    settle();
    check_out("mc5_done", 6'b000000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_ex_short();
    tick();
    ex_start  = 1'b1;
    ex_cycles = 6'd0;
    settle();
    check_out("ex0_same", 6'b000000, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_out("ex0_next", 6'b000000, 1'b0, 32'd0, 1'b0);
    ex_start  = 1'b1;
    ex_cycles = 6'd1;
    settle();
    check_out("ex1_same", 6'b001111, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_out("ex1_next", 6'b000000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_stallreq();
    tick();
    stallreq_id = 1'b1;
    settle();
    check_out("id_only", 6'b000111, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_out("id_released", 6'b000000, 1'b0, 32'd0, 1'b0);
    stallreq_ex = 1'b1;
    settle();
    check_out("ex_only", 6'b001111, 1'b0, 32'd0, 1'b0);
    stallreq_id = 1'b1;
    settle();
    check_out("ex_and_id", 6'b001111, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_out("both_released", 6'b000000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_ignore_in_busy();
    tick();
    ex_start  = 1'b1;
    ex_cycles = 6'd3;
    settle();
    check_out("ign_start", 6'b001111, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      ex_start    = 1'b1;
      ex_cycles   = 6'd9;
      stallreq_id = 1'b1;
      settle();
      check_out($sformatf("ign_busy%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1);
    end
    tick();
    idle_inputs();
    settle();
    check_out("ign_done", 6'b000000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_flush();
    tick();
    ex_start  = 1'b1;
    ex_cycles = 6'd8;
    settle();
    tick();
    idle_inputs();
    tick();
    tick();
    flush_req = 1'b1;
    new_pc_in = 32'hBFC0_0380;
    settle();
    check_out("flush_in_busy", 6'b000000, 1'b1, 32'hBFC0_0380, 1'b1);
    tick();
    idle_inputs();
    settle();
    check_out("flush_after", 6'b000000, 1'b0, 32'd0, 1'b0);
    flush_req   = 1'b1;
    new_pc_in   = 32'h1234_5678;
    stallreq_ex = 1'b1;
    settle();
    check_out("flush_over_stall", 6'b000000, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    tick();
    ex_start  = 1'b1;
    ex_cycles = 6'd11;
    tick();
    idle_inputs();
    tick();
    settle();
    check_out("rst_pre", 6'b001111, 1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    #1;
    check_out("rst_async", 6'b000000, 1'b0, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check_out($sformatf("rst_after%0d", i), 6'b000000, 1'b0, 32'd0, 1'b0);
    end
  endtask

  task automatic test_watchdog();
    int bad;
    do_reset();
    stallreq_ex = 1'b1;
    bad = 0;
`ifdef PIPE_CTRL_WATCHDOG_EN
    settle();
    for (int i = 1; i <= 254; i++) begin
      if (stall !== 6'b001111 || flush !== 1'b0) bad++;
      tick();
      settle();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wdog_pre: %0d of 254 cycles deviated, want 0", bad);
    end
    check_out("wdog_fire", 6'b000000, 1'b1, 32'h0000_0020, 1'b0);
    tick();
    settle();
    n_cmp++;
    if (wd_err !== 1'b1 || stall !== 6'b001111) begin
      n_err++;
      $display("FAIL wdog_err_set: got wd_err=%b stall=%b want 1 001111", wd_err, stall);
    end
    for (int i = 256; i < 300; i++) tick();
    settle();
    n_cmp++;
    if (wd_err !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_sticky: got %b want 1", wd_err);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (wd_err !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_reset: got %b want 0", wd_err);
    end
    tick();
    rst = 1'b1;
`else
    settle();
    for (int i = 1; i <= 300; i++) begin
      if (stall !== 6'b001111 || flush !== 1'b0 || wd_err !== 1'b0) bad++;
      tick();
      settle();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL nowdog_hold: %0d of 300 cycles deviated, want 0", bad);
    end
    idle_inputs();
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_multicycle();
    test_ex_short();
    test_stallreq();
    test_ignore_in_busy();
    test_flush();
    test_reset_mid_busy();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
